// File: rtl/quad_enc_decoder.sv
// Quadrature decoder: 2-flop sync + glitch filter per channel, x4 Gray decode to a wrapping signed count.
// Define QE_VELOCITY_EN to add windowed velocity measurement (velocity/vel_valid); otherwise they read 0.

module qe_chan_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt
);
  logic [1:0] sync_q;
  logic [3:0] cnt_q;

  // Counter tracks how long the synced level has disagreed with the filtered level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end
endmodule

module quad_enc_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int VEL_PERIOD  = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          quad_A,
  input  logic                          quad_B,
  input  logic                          quad_I,
  input  logic                          index_clear_en,
  input  logic                          clear_count,
  input  logic                          clear_error,
  output logic signed [COUNT_WIDTH-1:0] count,
  output logic                          direction,
  output logic                          count_strobe,
  output logic                          index_seen,
  output logic                          error,
  output logic signed [15:0]            velocity,
  output logic                          vel_valid
);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  // Encoding is the {A,B} code itself, listed in up order.
  typedef enum logic [1:0] {PH0 = 2'b00, PH1 = 2'b10, PH2 = 2'b11, PH3 = 2'b01} phase_t;

  logic [2:0] raw, filt;
  logic [1:0] curr_ab;
  phase_t     state_q, state_d, up_nxt, dn_nxt;
  logic       step_up, step_dn, illegal;
  logic       idx_prev_q, idx_rise;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic dir_q, dir_d, strobe_q, strobe_d, seen_q, seen_d, err_q, err_d;

  assign raw = {quad_I, quad_B, quad_A};

  for (genvar g = 0; g < 3; g++) begin : g_chan
    qe_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk),
      .reset(reset),
      .din  (raw[g]),
      .filt (filt[g])
    );
  end

  assign curr_ab  = {filt[0], filt[1]};
  assign idx_rise = filt[2] & ~idx_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PH0;
      idx_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_prev_q <= filt[2];
    end
  end

  // The state always follows the filtered code, so an illegal jump resynchronises.
  always_comb begin
    state_d = phase_t'(curr_ab);
    up_nxt  = PH1;
    dn_nxt  = PH3;
    unique case (state_q)
      PH0: begin up_nxt = PH1; dn_nxt = PH3; end
      PH1: begin up_nxt = PH2; dn_nxt = PH0; end
      PH2: begin up_nxt = PH3; dn_nxt = PH1; end
      PH3: begin up_nxt = PH0; dn_nxt = PH2; end
      default: ;
    endcase
    step_up = (curr_ab == up_nxt);
    step_dn = (curr_ab == dn_nxt);
    illegal = (curr_ab == ~state_q);
  end

  // Priority: clear_count, then index clear, then A/B step.
  always_comb begin
    count_d  = count_q;
    dir_d    = dir_q;
    strobe_d = 1'b0;
    seen_d   = seen_q;
    err_d    = err_q;
    if (clear_error) err_d = 1'b0;
    if (illegal)     err_d = 1'b1;
    if (clear_count) begin
      count_d  = '0;
      seen_d   = 1'b0;
      strobe_d = 1'b1;
    end else begin
      if (idx_rise) seen_d = 1'b1;
      if (idx_rise && index_clear_en) begin
        count_d  = '0;
        strobe_d = 1'b1;
      end else if (step_up) begin
        count_d  = count_q + ONE;
        dir_d    = 1'b1;
        strobe_d = 1'b1;
      end else if (step_dn) begin
        count_d  = count_q - ONE;
        dir_d    = 1'b0;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      dir_q    <= 1'b0;
      strobe_q <= 1'b0;
      seen_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      dir_q    <= dir_d;
      strobe_q <= strobe_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
    end
  end

  assign count        = count_q;
  assign direction    = dir_q;
  assign count_strobe = strobe_q;
  assign index_seen   = seen_q;
  assign error        = err_q;

`ifdef QE_VELOCITY_EN
  localparam int WIN_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;

  logic [WIN_W-1:0]   win_q;
  logic signed [31:0] acc_q, delta;
  logic signed [15:0] vel_q;
  logic               vel_vld_q;

  assign delta = step_up ? 32'sd1 : (step_dn ? -32'sd1 : 32'sd0);

  // Accumulator is wider than the output so saturation sees the true window total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q     <= '0;
      acc_q     <= '0;
      vel_q     <= '0;
      vel_vld_q <= 1'b0;
    end else if (win_q == WIN_W'(VEL_PERIOD - 1)) begin
      win_q     <= '0;
      acc_q     <= delta;
      vel_vld_q <= 1'b1;
      if (acc_q > 32'sd32767)       vel_q <= 16'sh7FFF;
      else if (acc_q < -32'sd32768) vel_q <= 16'sh8000;
      else                          vel_q <= acc_q[15:0];
    end else begin
      win_q     <= win_q + WIN_W'(1);
      acc_q     <= acc_q + delta;
      vel_vld_q <= 1'b0;
    end
  end

  assign velocity  = vel_q;
  assign vel_valid = vel_vld_q;
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif
endmodule
